// File: rtl/pwm_pkg.sv
// Shared PWM definitions: gate FSM encoding and default carrier/dead-time sizing.
package pwm_pkg;

  localparam int CLK_HZ       = 50_000_000;
  localparam int PWM_WIDTH    = 8;
  localparam int PWM_DEADTIME = 50;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DT    = 2'd1,
    ST_HI_ON = 2'd2,
    ST_LO_ON = 2'd3
  } pwm_state_e;

endpackage

// File: rtl/carrier_edge_detect.sv
// Tracks the slope of the triangular carrier and flags valley/peak turnarounds
// combinationally in the cycle the reversed sample arrives.
module carrier_edge_detect #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] carrier,
  output logic             valley,
  output logic             peak
);

  logic [WIDTH-1:0] carrier_prev_reg;
  logic             slope_up_reg;
  logic             slope_up_next;

  // Equal consecutive samples satisfy neither compare, so plateaus hold the slope.
  assign valley = !slope_up_reg && (carrier > carrier_prev_reg);
  assign peak   =  slope_up_reg && (carrier < carrier_prev_reg);

  always_comb begin
    slope_up_next = slope_up_reg;
    if (valley) begin
      slope_up_next = 1'b1;
    end else if (peak) begin
      slope_up_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      carrier_prev_reg <= '0;
      slope_up_reg     <= 1'b1;
    end else begin
      carrier_prev_reg <= carrier;
      slope_up_reg     <= slope_up_next;
    end
  end

endmodule

// File: rtl/pwm_deadtime_comparator.sv
// Carrier/reference comparator driving a complementary gate pair with
// programmable dead time, a shadowed reference and a per-period sync pulse.
module pwm_deadtime_comparator
  import pwm_pkg::*;
#(
  parameter int WIDTH        = PWM_WIDTH,
  parameter int DEADTIME     = PWM_DEADTIME,
  parameter int DT_W         = 8,
  parameter int LOAD_ON_PEAK = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] carrier,
  input  logic [WIDTH-1:0] ref_in,
  output logic             gate_hi,
  output logic             gate_lo,
  output logic             period_sync,
  output logic [WIDTH-1:0] ref_active
);

  localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DEADTIME);
  localparam logic [DT_W-1:0] DT_ONE  = DT_W'(1);

  logic             valley;
  logic             peak;
  logic             load_event;
  logic [WIDTH-1:0] ref_active_reg;
  logic             period_sync_reg;
  logic             raw_q_reg;
  pwm_state_e       state_reg;
  pwm_state_e       state_next;
  logic [DT_W-1:0]  dt_cnt_reg;
  logic [DT_W-1:0]  dt_cnt_next;

  carrier_edge_detect #(
    .WIDTH (WIDTH)
  ) u_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .carrier (carrier),
    .valley  (valley),
    .peak    (peak)
  );

  assign load_event = valley || ((LOAD_ON_PEAK != 0) && peak);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ref_active_reg  <= '0;
      period_sync_reg <= 1'b0;
      raw_q_reg       <= 1'b0;
      state_reg       <= ST_IDLE;
      dt_cnt_reg      <= '0;
    end else begin
      period_sync_reg <= valley;
      if (load_event) begin
        ref_active_reg <= ref_in;
      end
      raw_q_reg       <= (ref_active_reg > carrier);
      state_reg       <= state_next;
      dt_cnt_reg      <= dt_cnt_next;
    end
  end

  // The dead interval ignores raw_q until its last cycle, so comparator
  // chatter inside the band can never shorten it.
  always_comb begin
    state_next  = state_reg;
    dt_cnt_next = dt_cnt_reg;
    if (!enable) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_next  = ST_DT;
          dt_cnt_next = DT_LOAD;
        end
        ST_DT: begin
          dt_cnt_next = dt_cnt_reg - DT_ONE;
          if (dt_cnt_reg == DT_ONE) begin
            state_next = raw_q_reg ? ST_HI_ON : ST_LO_ON;
          end
        end
        ST_HI_ON: begin
          if (!raw_q_reg) begin
            state_next  = ST_DT;
            dt_cnt_next = DT_LOAD;
          end
        end
        ST_LO_ON: begin
          if (raw_q_reg) begin
            state_next  = ST_DT;
            dt_cnt_next = DT_LOAD;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Decoding straight from the state flops lets the async reset drop the gates at once.
  assign gate_hi     = (state_reg == ST_HI_ON);
  assign gate_lo     = (state_reg == ST_LO_ON);
  assign period_sync = period_sync_reg;
  assign ref_active  = ref_active_reg;

endmodule

// File: tb/tb_pwm_deadtime_comparator.sv
// Randomized bench for pwm_deadtime_comparator against a behavioural model of
// the carrier slope, shadow reference, comparator and dead-time gate sequence.
module tb_pwm_deadtime_comparator;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [7:0] carrier;
  logic [7:0] ref_in;

  logic       gate_hi, gate_lo, period_sync;
  logic [7:0] ref_active;
  logic       gate_hi_pk, gate_lo_pk, period_sync_pk;
  logic [7:0] ref_active_pk;

  int checks = 0;
  int errors = 0;

  // model state
  logic [7:0] m_prev, m_ref, m_ref_pk;
  logic       m_slope_up, m_sync, m_raw;
  int         m_on;    // 0 none, 1 high side conducting, 2 low side conducting
  int         m_dead;  // dead cycles still owed before a gate may rise; 0 with m_on==0 means idle

  logic car_up;
  int   hold_cnt;

  always #5 clk = ~clk;

  pwm_deadtime_comparator #(
    .WIDTH(8), .DEADTIME(D), .DT_W(8), .LOAD_ON_PEAK(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .carrier(carrier), .ref_in(ref_in),
    .gate_hi(gate_hi), .gate_lo(gate_lo), .period_sync(period_sync), .ref_active(ref_active)
  );

  pwm_deadtime_comparator #(
    .WIDTH(8), .DEADTIME(D), .DT_W(8), .LOAD_ON_PEAK(1)
  ) dut_pk (
    .clk(clk), .reset_n(reset_n), .enable(enable), .carrier(carrier), .ref_in(ref_in),
    .gate_hi(gate_hi_pk), .gate_lo(gate_lo_pk), .period_sync(period_sync_pk), .ref_active(ref_active_pk)
  );

  assert property (@(negedge clk) disable iff (!reset_n) !(gate_hi && gate_lo))
    else $error("gate overlap on main instance");
  assert property (@(negedge clk) disable iff (!reset_n) !(gate_hi_pk && gate_lo_pk))
    else $error("gate overlap on peak-load instance");

  function automatic logic [19:0] obs_vec();
    return {gate_hi, gate_lo, period_sync, period_sync_pk, ref_active, ref_active_pk};
  endfunction

  function automatic logic [19:0] exp_vec();
    return {(m_on == 1), (m_on == 2), m_sync, m_sync, m_ref, m_ref_pk};
  endfunction

  task automatic model_reset();
    m_prev = 8'd0; m_ref = 8'd0; m_ref_pk = 8'd0;
    m_slope_up = 1'b1; m_sync = 1'b0; m_raw = 1'b0;
    m_on = 0; m_dead = 0;
  endtask

  // One clock: the model absorbs the inputs the DUT just sampled, then outputs settle.
  task automatic step();
    logic valley, peak, n_raw;
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      valley = !m_slope_up && (carrier > m_prev);
      peak   =  m_slope_up && (carrier < m_prev);
      if (!enable) begin
        m_on = 0; m_dead = 0;
      end else if (m_on == 0 && m_dead == 0) begin
        m_dead = D;
      end else if (m_on == 0) begin
        if (m_dead == 1) begin
          m_on = m_raw ? 1 : 2; m_dead = 0;
        end else begin
          m_dead--;
        end
      end else if ((m_on == 1) != m_raw) begin
        m_on = 0; m_dead = D;
      end
      n_raw = (m_ref > carrier);
      if (valley) m_ref = ref_in;
      if (valley || peak) m_ref_pk = ref_in;
      m_sync = valley;
      if (valley) m_slope_up = 1'b1;
      else if (peak) m_slope_up = 1'b0;
      m_prev = carrier;
      m_raw  = n_raw;
    end
    #1;
  endtask

  task automatic advance_carrier(input int stp, input int hold);
    int c;
    c = int'(carrier);
    if (car_up) begin
      if (c == 255) begin
        if (hold_cnt < hold) hold_cnt++;
        else begin hold_cnt = 0; car_up = 1'b0; c = 255 - stp; end
      end else if (c + stp >= 255) c = 255;
      else c = c + stp;
    end else begin
      if (c == 0) begin car_up = 1'b1; c = stp; end
      else if (c <= stp) c = 0;
      else c = c - stp;
    end
    carrier = 8'(c);
  endtask

  task automatic test_reset();
    int lows;
    bit rose;
    reset_n = 1'b0; enable = 1'b1; ref_in = 8'd77;
    for (int i = 0; i < 6; i++) begin
      advance_carrier(1, 0); step();
      checks++;
      if (obs_vec() !== 20'd0) begin
        errors++; $display("FAIL reset_hold obs=%h exp=%h", obs_vec(), 20'd0);
      end
    end
    reset_n = 1'b1; lows = 0; rose = 0;
    for (int i = 0; i < 20 && !rose; i++) begin
      advance_carrier(1, 0); step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL reset_release obs=%h exp=%h", obs_vec(), exp_vec());
      end
      if (gate_hi || gate_lo) rose = 1; else lows++;
    end
    checks++;
    if (!rose || lows != D || gate_lo !== 1'b1) begin
      errors++; $display("FAIL reset_deadband obs lows=%0d lo=%b exp lows=%0d lo=1", lows, gate_lo, D);
    end
    $display("test_reset: low cycles after release=%0d", lows);
  endtask

  task automatic test_steady_compare();
    int last_on, run, bands, hi_cycles;
    ref_in = 8'd128; last_on = 0; run = 0; bands = 0; hi_cycles = 0;
    for (int i = 0; i < 1600; i++) begin
      advance_carrier(1, 0); step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL steady obs=%h exp=%h", obs_vec(), exp_vec());
      end
      if (gate_hi) hi_cycles++;
      if (gate_hi || gate_lo) begin
        if (last_on != 0 && run > 0) begin
          checks++; bands++;
          if (run != D) begin
            errors++; $display("FAIL steady_deadband obs=%0d exp=%0d", run, D);
          end
        end
        last_on = gate_hi ? 1 : 2; run = 0;
      end else begin
        run++;
      end
    end
    $display("test_steady_compare: dead bands=%0d hi cycles=%0d", bands, hi_cycles);
  endtask

  task automatic test_shadow_load();
    bit done;
    int syncs;
    ref_in = 8'd100; done = 0;
    for (int i = 0; i < 1200 && !done; i++) begin
      advance_carrier(1, 0); step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL shadow_prep obs=%h exp=%h", obs_vec(), exp_vec());
      end
      done = period_sync;
    end
    for (int i = 0; i < 600 && carrier < 8'd120; i++) begin
      advance_carrier(1, 0); step();
    end
    ref_in = 8'd200; done = 0;
    for (int i = 0; i < 600 && !done; i++) begin
      advance_carrier(1, 0); step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL shadow_model obs=%h exp=%h", obs_vec(), exp_vec());
      end
      if (carrier == 8'd255) begin
        checks++;
        if (ref_active_pk !== 8'd100) begin
          errors++; $display("FAIL shadow_prepeak obs=%0d exp=100", ref_active_pk);
        end
      end
      checks++;
      if (period_sync) begin
        done = 1;
        if (ref_active !== 8'd200 || ref_active_pk !== 8'd200) begin
          errors++; $display("FAIL shadow_after_valley obs=%0d/%0d exp=200/200", ref_active, ref_active_pk);
        end
      end else if (ref_active !== 8'd100) begin
        errors++; $display("FAIL shadow_hold obs=%0d exp=100", ref_active);
      end
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL shadow_timeout obs=no_sync exp=sync");
    end
    syncs = 0;
    for (int i = 0; i < 1020; i++) begin
      advance_carrier(1, 0); step();
      if (period_sync) syncs++;
    end
    checks++;
    if (syncs != 2) begin
      errors++; $display("FAIL sync_rate obs=%0d exp=2", syncs);
    end
    $display("test_shadow_load: ref_active=%0d syncs in two periods=%0d", ref_active, syncs);
  endtask

  task automatic test_extremes();
    bit done;
    int lo_rises;
    logic lo_d;
    ref_in = 8'd0; done = 0;
    for (int i = 0; i < 1200 && !done; i++) begin
      advance_carrier(1, 0); step(); done = period_sync;
    end
    for (int i = 0; i < 30; i++) begin
      advance_carrier(1, 0); step();
    end
    for (int i = 0; i < 400; i++) begin
      advance_carrier(1, 0); step();
      checks++;
      if (gate_lo !== 1'b1 || gate_hi !== 1'b0 || obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL ref_zero obs=%h exp=%h", obs_vec(), exp_vec());
      end
    end
    ref_in = 8'd255; done = 0;
    for (int i = 0; i < 1200 && !done; i++) begin
      advance_carrier(1, 8); step(); done = period_sync;
    end
    for (int i = 0; i < 600 && carrier <= 8'd128; i++) begin
      advance_carrier(1, 8); step();
    end
    lo_rises = 0; lo_d = gate_lo;
    for (int i = 0; i < 1040; i++) begin
      advance_carrier(1, 8); step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL ref_full obs=%h exp=%h", obs_vec(), exp_vec());
      end
      if (gate_lo && !lo_d) lo_rises++;
      lo_d = gate_lo;
    end
    checks++;
    if (lo_rises != 2) begin
      errors++; $display("FAIL ref_full_pulses obs=%0d exp=2", lo_rises);
    end
    $display("test_extremes: low-side pulses at full reference=%0d", lo_rises);
  endtask

  task automatic test_glitch_dt();
    bit done, lo_seen;
    int lows;
    ref_in = 8'd128; done = 0;
    for (int i = 0; i < 1200 && !done; i++) begin
      advance_carrier(1, 0); step(); done = period_sync;
    end
    carrier = 8'd50;
    for (int i = 0; i < 12; i++) step();
    checks++;
    if (gate_hi !== 1'b1) begin
      errors++; $display("FAIL glitch_setup obs=%b exp=1", gate_hi);
    end
    lows = 0; lo_seen = 0;
    for (int i = 0; i < 16; i++) begin
      carrier = (i == 2) ? 8'd50 : 8'd200;
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL glitch_model obs=%h exp=%h", obs_vec(), exp_vec());
      end
      if (gate_lo) lo_seen = 1;
      else if (!gate_hi && !lo_seen) lows++;
    end
    checks++;
    if (lows != D || !lo_seen || gate_lo !== 1'b1 || gate_hi !== 1'b0) begin
      errors++; $display("FAIL glitch_deadband obs lows=%0d lo=%b exp lows=%0d lo=1", lows, gate_lo, D);
    end
    $display("test_glitch_dt: dead band with chatter=%0d", lows);
  endtask

  task automatic test_enable_drop();
    int lows;
    bit rose;
    carrier = 8'd50; rose = 0;
    for (int i = 0; i < 20 && !rose; i++) begin
      step(); rose = gate_hi;
    end
    checks++;
    if (!rose) begin
      errors++; $display("FAIL enable_setup obs=%b exp=1", gate_hi);
    end
    enable = 1'b0; step();
    checks++;
    if (gate_hi !== 1'b0 || gate_lo !== 1'b0 || obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL enable_drop obs=%h exp=%h", obs_vec(), exp_vec());
    end
    for (int i = 0; i < 3; i++) step();
    enable = 1'b1; lows = 0; rose = 0;
    for (int i = 0; i < 20 && !rose; i++) begin
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL enable_resume obs=%h exp=%h", obs_vec(), exp_vec());
      end
      if (gate_hi || gate_lo) rose = 1; else lows++;
    end
    checks++;
    if (!rose || lows != D || gate_hi !== 1'b1) begin
      errors++; $display("FAIL enable_deadband obs lows=%0d hi=%b exp lows=%0d hi=1", lows, gate_hi, D);
    end
    $display("test_enable_drop: low cycles after re-enable=%0d", lows);
  endtask

  task automatic test_async_reset();
    bit rose;
    carrier = 8'd50; rose = 0;
    for (int i = 0; i < 20 && !rose; i++) begin
      step(); rose = gate_hi || gate_lo;
    end
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if (!rose || gate_hi !== 1'b0 || gate_lo !== 1'b0 || ref_active !== 8'd0) begin
      errors++; $display("FAIL async_reset obs hi=%b lo=%b ref=%0d exp 0/0/0", gate_hi, gate_lo, ref_active);
    end
    model_reset();
    #2 reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      advance_carrier(3, 0); step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL async_recover obs=%h exp=%h", obs_vec(), exp_vec());
      end
    end
    $display("test_async_reset: gates released without clock edge");
  endtask

  task automatic test_random();
    int off, bad;
    off = 0; bad = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 63) == 0) ref_in = 8'($urandom_range(0, 255));
      if (enable && $urandom_range(0, 199) == 0) begin
        enable = 1'b0; off = $urandom_range(1, 5);
      end else if (!enable) begin
        if (off == 0) enable = 1'b1; else off--;
      end
      advance_carrier($urandom_range(1, 6), $urandom_range(0, 2));
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; bad++; $display("FAIL random obs=%h exp=%h cycle=%0d", obs_vec(), exp_vec(), i);
      end
    end
    enable = 1'b1;
    $display("test_random: 3000 cycles, deviations=%0d", bad);
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b1; carrier = 8'd0; ref_in = 8'd0;
    car_up = 1'b1; hold_cnt = 0;
    model_reset();
    test_reset();
    test_steady_compare();
    test_shadow_load();
    test_extremes();
    test_glitch_dt();
    test_enable_drop();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
